dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory interface (dmem_addr/dmem_wdata/dmem_byte_en/dmem_wen/dmem_rdata).
- Serves a byte-enabled 64-bit RAM region and a small MMIO region. The MMIO region holds a free-running cycle timer, a tohost mailbox and a console TX FIFO that drains through an 8N1 serial transmitter.
- Instantiated beside the core in the SoC/testbench top.

Parameters:
- RAM_WORDS, 4096, depth of RAM in 64-bit words (power of two).
- MMIO_BASE, 64'h0000_0000_1000_0000, base address of the MMIO block (4 KiB window).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2).
- BAUD_DIV, 16, clock cycles per serial bit (≥2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- dmem_addr  input  64  byte address from the core; bits [2:0] ignored (lane-based access).
- dmem_wdata  input  64  write data, lane-aligned.
- dmem_byte_en  input  8  per-byte-lane write/read enable.
- dmem_wen  input  1  write strobe, one write per cycle when high.
- dmem_rdata  output  64  read data, combinational from address.
- tx_o  output  1  serial console output, idle high.
- tohost_valid_o  output  1  sticky: tohost written since reset.
- tohost_data_o  output  64  last value written to TOHOST.

Behaviour:
- Reset values:
  - dmem_rdata follows the address (RAM contents undefined).
  - tx_o=1, tohost_valid_o=0, tohost_data_o=0.
  - mtime=0, FIFO empty, overflow=0, TX FSM in IDLE.
  - Reset asserted mid-frame aborts the frame and drives tx_o=1 immediately.
- Decode:
  - RAM hit: addr < RAM_WORDS*8; word index = addr[3+:log2(RAM_WORDS)].
  - MMIO hit: addr[63:12] == MMIO_BASE[63:12]; register offset = addr[11:3].
  - Any other address: reads 0, writes ignored.
- Reads:
  - Zero-latency combinational; unenabled lanes are not masked (the core extracts lanes).
  - A read of a RAM word written in the same cycle returns the old data.
- RAM writes:
  - On posedge with dmem_wen=1, each lane i with byte_en[i]=1 is updated.
  - byte_en=0 with wen=1 is a no-op.
- MMIO map (offset in bytes):
  - 0x00 MTIME, RO: 64-bit counter, +1 every cycle, wraps 2^64-1→0. Writes ignored.
  - 0x08 TOHOST, WO (reads return tohost_data_o): a write with any byte_en set stores the full wdata and sets tohost_valid_o (sticky until reset).
  - 0x10 TXDATA, WO (reads 0): a write with byte_en[0]=1 pushes wdata[7:0].
    - The push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
    - Otherwise the byte is dropped and overflow is set.
  - 0x18 STATUS, RW:
    - Read fields: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow, bits[15:8] count; other bits 0.
    - Writing 1 to bit3 (byte_en[0]) clears overflow; a clear and a new overflow in the same cycle leaves overflow=1.
- TX FSM (in sub-module), BAUD_DIV-cycle bit timer:
  - IDLE: if FIFO non-empty, pop one byte into the shift register (pop visible in count next cycle) and go to START.
  - START: tx_o=0 for BAUD_DIV cycles, then DATA.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each, then STOP.
  - STOP: tx_o=1 for BAUD_DIV cycles, then IDLE.
  - Back-to-back bytes: the IDLE→START decision is made in the cycle after STOP ends. Frame period = 10*BAUD_DIV + 1 cycles.
  - tx_busy = (state != IDLE).

Decomposition:
- Shared package riscv_pkg gains:
  - MMIO offset localparams (MMIO_MTIME, MMIO_TOHOST, MMIO_TXDATA, MMIO_STATUS).
  - STATUS bit-index constants.
  - uart_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module, uart_tx: inputs byte and valid, outputs pop/ready and tx_o; parameter BAUD_DIV.
- RAM, decode, timer, mailbox and FIFO stay in dmem_responder.

Test Plan:
- RAM byte-enable: write 64'h1122334455667788 to 0x40 with be=8'hFF, then 64'hAAAA… with be=8'h0F → read 0x40 returns 64'h11223344AAAAAAAA.
- Unmapped access and timer:
  - Write to 0x2000_0000 leaves all state unchanged.
  - Reads of 0x2000_0000 and MMIO offset 0x20 return 0.
  - MTIME read N cycles after reset deassertion returns N.
- TOHOST: write 64'h1 to MMIO_BASE+0x08 → next cycle tohost_valid_o=1, tohost_data_o=1; holds through later non-TOHOST writes.
- Serial frame: with BAUD_DIV=4, push 8'hA5 → tx_o low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4; STATUS.tx_busy=1 during the frame, empty=1 after.
- FIFO overflow:
  - With FIFO_DEPTH=4, push 6 bytes in consecutive cycles: the first byte is popped, so 5 are accepted and the 6th is dropped.
  - STATUS then reads full=1, overflow=1, count=4.
  - Writing 8'h08 to STATUS clears overflow.
  - Exactly the 5 accepted bytes are serialized, in order.
- Reset mid-frame: assert rst during DATA bit 3 → tx_o=1 immediately, FIFO empty, tohost_valid_o=0, MTIME=0 on release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder.
//   MMIO_*      : byte offsets of the MMIO registers inside the 4 KiB window
//   ST_*        : bit positions of the STATUS register fields
//   uart_state_t: console transmitter states
package riscv_pkg;

    localparam logic [11:0] MMIO_MTIME  = 12'h000;
    localparam logic [11:0] MMIO_TOHOST = 12'h008;
    localparam logic [11:0] MMIO_TXDATA = 12'h010;
    localparam logic [11:0] MMIO_STATUS = 12'h018;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed from a byte FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   data     : byte at the FIFO head
//   valid    : FIFO non-empty
//   pop      : head byte taken this cycle (only in IDLE)
//   busy     : a frame is in progress (state != IDLE)
//   tx_o     : registered serial line, idle high
module uart_tx
    import riscv_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       pop,
    output logic       busy,
    output logic       tx_o
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    uart_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == CW'(BAUD_DIV - 1));
    assign pop     = (state == IDLE) && valid;
    assign busy    = (state != IDLE);

    // tx_o is registered, so each state change also loads the level the line
    // must carry for the following BAUD_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_o     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (valid) begin
                        shreg <= data;
                        state <= START;
                        tx_o  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx_o     <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            // LSB first: shift the next bit into position 0
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory interface: byte-enabled RAM plus
// an MMIO window with cycle timer, tohost mailbox and console TX FIFO.
//   clk, rst       : clock, asynchronous active-high reset
//   dmem_addr      : byte address (bits [2:0] ignored)
//   dmem_wdata     : lane-aligned write data
//   dmem_byte_en   : per-lane enable
//   dmem_wen       : write strobe
//   dmem_rdata     : combinational read data
//   tx_o           : serial console output
//   tohost_valid_o : sticky, TOHOST written since reset
//   tohost_data_o  : last value written to TOHOST
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          BAUD_DIV   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_wdata,
    input  logic [7:0]  dmem_byte_en,
    input  logic        dmem_wen,
    output logic [63:0] dmem_rdata,
    output logic        tx_o,
    output logic        tohost_valid_o,
    output logic [63:0] tohost_data_o
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [63:0] ram [RAM_WORDS];
    logic [7:0]  fifo [FIFO_DEPTH];

    logic          ram_hit, mmio_hit;
    logic [11:0]   reg_off;
    logic [AW-1:0] ram_idx;
    logic [63:0]   mtime;
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   count;
    logic          overflow, full, empty;
    logic          push_req, push_ok, pop, ovf_clr, tx_busy;
    logic [63:0]   status;

    // RAM takes priority should the MMIO window ever overlap it
    assign ram_hit  = dmem_addr < (64'(RAM_WORDS) << 3);
    assign mmio_hit = !ram_hit && (dmem_addr[63:12] == MMIO_BASE[63:12]);
    assign reg_off  = {dmem_addr[11:3], 3'b000};
    assign ram_idx  = dmem_addr[3 +: AW];

    assign full  = (count == (FW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    assign push_req = dmem_wen && mmio_hit && (reg_off == MMIO_TXDATA) && dmem_byte_en[0];
    // A full FIFO still accepts when the transmitter frees a slot this cycle
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = dmem_wen && mmio_hit && (reg_off == MMIO_STATUS)
                      && dmem_byte_en[0] && dmem_wdata[ST_OVF];

    always_comb begin
        status                   = '0;
        status[ST_FULL]          = full;
        status[ST_EMPTY]         = empty;
        status[ST_BUSY]          = tx_busy;
        status[ST_OVF]           = overflow;
        status[ST_CNT_LSB +: 8]  = 8'(count);
    end

    always_comb begin
        dmem_rdata = '0;
        if (ram_hit) begin
            dmem_rdata = ram[ram_idx];
        end else if (mmio_hit) begin
            case (reg_off)
                MMIO_MTIME:  dmem_rdata = mtime;
                MMIO_TOHOST: dmem_rdata = tohost_data_o;
                MMIO_STATUS: dmem_rdata = status;
                default:     dmem_rdata = '0;
            endcase
        end
    end

    // Storage arrays carry no reset; their contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (dmem_wen && ram_hit) begin
            for (int i = 0; i < 8; i++) begin
                if (dmem_byte_en[i]) ram[ram_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
        end
        if (push_ok) fifo[wr_ptr] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime          <= '0;
            tohost_valid_o <= 1'b0;
            tohost_data_o  <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
        end else begin
            mtime <= mtime + 64'd1;
            if (dmem_wen && mmio_hit && (reg_off == MMIO_TOHOST) && (|dmem_byte_en)) begin
                tohost_valid_o <= 1'b1;
                tohost_data_o  <= dmem_wdata;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a new drop wins over a clear in the same cycle
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .data (fifo[rd_ptr]),
        .valid(!empty),
        .pop  (pop),
        .busy (tx_busy),
        .tx_o (tx_o)
    );

endmodule
